// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF custom-3 coprocessor responder.
package cvxif_copro_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ID_WIDTH = 2;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam int unsigned PTR_W    = IDX_W + 1;
   localparam int unsigned COUNT_W  = 4;
   localparam int unsigned LAT_W    = 5;

   localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
   localparam logic [2:0] F3_ADD         = 3'b000;
   localparam logic [2:0] F3_ADD_MULTI   = 3'b001;
   localparam logic [2:0] F3_SUB         = 3'b010;
   localparam logic [6:0] F7_ADD         = 7'd0;
   localparam logic [6:0] F7_NOP         = 7'd1;

   typedef enum logic [2:0] {
      OP_ILLEGAL,
      OP_ADD,
      OP_NOP,
      OP_ADD_MULTI,
      OP_SUB
   } op_e;

   typedef struct packed {
      logic             legal;
      op_e              op;
      logic             writes;
      logic [LAT_W-1:0] latency;
   } dec_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [4:0]          rd;
      logic                we;
      logic [XLEN-1:0]     data;
      logic [COUNT_W-1:0]  count;
      logic                committed;
      logic                killed;
   } entry_t;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational decode of a custom-3 instruction word into legality, op, writeback and latency.
module cvxif_copro_decoder
   import cvxif_copro_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_rs_fields;

   assign opcode           = instr[6:0];
   assign funct3           = instr[14:12];
   assign funct7           = instr[31:25];
   assign unused_rs_fields = ^instr[24:15];

   always_comb begin
      dec.legal   = 1'b0;
      dec.op      = OP_ILLEGAL;
      dec.writes  = 1'b0;
      dec.latency = LAT_W'(1);
      if (opcode == OPCODE_CUSTOM3) begin
         case (funct3)
            F3_ADD: begin
               if (funct7 == F7_ADD) begin
                  dec.legal  = 1'b1;
                  dec.op     = OP_ADD;
                  dec.writes = 1'b1;
               end else if (funct7 == F7_NOP) begin
                  dec.legal = 1'b1;
                  dec.op    = OP_NOP;
               end
            end
            F3_ADD_MULTI: begin
               dec.legal   = 1'b1;
               dec.op      = OP_ADD_MULTI;
               dec.writes  = 1'b1;
               dec.latency = LAT_W'(funct7[3:0]) + LAT_W'(1);
            end
            F3_SUB: begin
               dec.legal  = 1'b1;
               dec.op     = OP_SUB;
               dec.writes = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: in-order entry FIFO with commit/kill tracking,
// per-entry latency counters and head-of-queue result retirement.
module cvxif_copro_responder
   import cvxif_copro_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [ID_WIDTH-1:0]   issue_id_i,
   input  logic [2*XLEN-1:0]     issue_rs_i,
   input  logic [1:0]            issue_rs_valid_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   input  logic                  commit_valid_i,
   input  logic [ID_WIDTH-1:0]   commit_id_i,
   input  logic                  commit_kill_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [ID_WIDTH-1:0]   result_id_o,
   output logic [XLEN-1:0]       result_data_o,
   output logic [4:0]            result_rd_o,
   output logic                  result_we_o
);

   entry_t             entries [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   used;
   logic               full;
   logic               empty;
   logic [DEPTH-1:0]   resident;
   logic [IDX_W-1:0]   offset;

   dec_t               dec;
   logic [4:0]         rd;
   logic [XLEN-1:0]    rs1;
   logic [XLEN-1:0]    rs2;
   logic               operands_ok;
   logic               accept;
   entry_t             new_entry;

   entry_t             head;
   logic               res_valid;
   logic               silent_pop;
   logic               pop;

   cvxif_copro_decoder u_decoder (
      .instr (issue_instr_i),
      .dec   (dec)
   );

   assign rd    = issue_instr_i[11:7];
   assign rs1   = issue_rs_i[XLEN-1:0];
   assign rs2   = issue_rs_i[2*XLEN-1:XLEN];
   assign used  = wr_ptr - rd_ptr;
   assign full  = (used == PTR_W'(DEPTH));
   assign empty = (wr_ptr == rd_ptr);

   // NOP carries no operands, so only the others wait on operand validity.
   assign operands_ok       = (dec.op == OP_NOP) || (&issue_rs_valid_i);
   assign issue_ready_o     = !full;
   assign accept            = issue_valid_i && issue_ready_o && dec.legal && operands_ok;
   assign issue_accept_o    = accept;
   assign issue_writeback_o = accept && dec.writes && (rd != 5'd0);

   always_comb begin
      new_entry           = '0;
      new_entry.id        = issue_id_i;
      new_entry.rd        = rd;
      new_entry.we        = dec.writes && (rd != 5'd0);
      new_entry.data      = (dec.op == OP_SUB) ? (rs1 - rs2) : (rs1 + rs2);
      new_entry.count     = COUNT_W'(dec.latency - LAT_W'(1));
      new_entry.committed = 1'b0;
      new_entry.killed    = 1'b0;
   end

   // Slots between rd_ptr and wr_ptr hold live entries.
   always_comb begin
      resident = '0;
      offset   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         offset      = IDX_W'(i) - rd_ptr[IDX_W-1:0];
         resident[i] = ({1'b0, offset} < used);
      end
   end

   assign head       = entries[rd_ptr[IDX_W-1:0]];
   assign res_valid  = !empty && head.committed && !head.killed && head.we && (head.count == '0);
   assign silent_pop = !empty && head.committed && (head.killed || !head.we);
   assign pop        = silent_pop || (res_valid && result_ready_i);

   assign result_valid_o = res_valid;
   assign result_id_o    = res_valid ? head.id   : '0;
   assign result_data_o  = res_valid ? head.data : '0;
   assign result_rd_o    = res_valid ? head.rd   : '0;
   assign result_we_o    = res_valid;

   // Counters and commit marks update only on entries present at cycle start.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (resident[i]) begin
               if (entries[i].count != '0) begin
                  entries[i].count <= entries[i].count - COUNT_W'(1);
               end
               if (commit_valid_i && !entries[i].committed && (entries[i].id == commit_id_i)) begin
                  entries[i].committed <= 1'b1;
                  entries[i].killed    <= commit_kill_i;
               end
            end
         end
         if (accept) begin
            entries[wr_ptr[IDX_W-1:0]] <= new_entry;
            wr_ptr                     <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

endmodule
